// File: rtl/guard_gate_pkg.sv
// Shared types for the guard-predicate consumer: FSM state encoding and
// the meaning of a predicate token.
package ep2_guard_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } guard_state_t;

   localparam logic GUARD_PASS = 1'b1;
   localparam logic GUARD_DROP = 1'b0;

   // State entered once a token has been handshaken.
   function automatic guard_state_t token_state(input logic tok);
      return (tok == GUARD_PASS) ? PASS : DROP;
   endfunction

endpackage

// File: rtl/guard_gate_if.sv
// Stream bundle for guard_gate: predicate token in, event stream in, gated stream out.
// All three channels use AXI-Stream rules: a transfer happens on a clock edge where
// tvalid and tready are both 1; once raised, tvalid and payload hold until that edge.
interface guard_gate_if #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
   logic                  s_guard_cond_tdata;
   logic                  s_guard_cond_tvalid;
   logic                  s_guard_cond_tready;
   logic [DATA_WIDTH-1:0] s_axis_tdata;
   logic [KEEP_WIDTH-1:0] s_axis_tkeep;
   logic                  s_axis_tlast;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic [DATA_WIDTH-1:0] m_axis_tdata;
   logic [KEEP_WIDTH-1:0] m_axis_tkeep;
   logic                  m_axis_tlast;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;

   modport slave (
      input  s_guard_cond_tdata, s_guard_cond_tvalid,
      output s_guard_cond_tready,
      input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
      input  m_axis_tready
   );

   modport master (
      output s_guard_cond_tdata, s_guard_cond_tvalid,
      input  s_guard_cond_tready,
      output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
      output m_axis_tready
   );

endinterface

// File: rtl/guard_gate_skid.sv
// Two-entry register slice: outputs come straight from flops, a pushed word is
// visible the next cycle, and the input side is ready whenever an entry is free.
module guard_skid #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready
);

   logic [1:0]       r_count;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic             w_push;
   logic             w_pop;

   assign o_ready = (r_count != 2'd2);
   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_head;
   assign w_push  = i_valid && o_ready;
   assign w_pop   = o_valid && i_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload flops carry no reset: r_count alone says which entries are live.
   always_ff @(posedge clk) begin
      if (w_push && ((r_count == 2'd0) || (w_pop && (r_count == 2'd1)))) begin
         r_head <= i_data;
      end else if (w_pop) begin
         r_head <= r_tail;
      end
      if (w_push && !w_pop && (r_count == 2'd1)) begin
         r_tail <= i_data;
      end
   end

endmodule

// File: rtl/guard_gate.sv
// Consumer end of the guard-predicate path: each predicate token either forwards
// or silently drops the next frame of the event stream, and frames are counted.
module guard_gate
   import ep2_guard_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int IF_STREAM  = 1,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   guard_gate_if.slave          bus,
   output logic [CNT_WIDTH-1:0] stat_pass_cnt,
   output logic [CNT_WIDTH-1:0] stat_drop_cnt,
   output guard_state_t         o_dbg_state
);

   localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   guard_state_t         r_state;
   guard_state_t         w_next;
   logic [CNT_WIDTH-1:0] r_pass_cnt;
   logic [CNT_WIDTH-1:0] r_drop_cnt;
   logic                 w_last;
   logic                 w_skid_ready;
   logic                 w_push;
   logic                 w_guard_ready;
   logic                 w_s_ready;
   logic                 w_inc_pass;
   logic                 w_inc_drop;
   logic                 w_end;
   logic [PW-1:0]        w_skid_out;

   // In single-beat mode every beat closes its event; the forwarded tlast
   // carries that effective value so downstream still sees framed events.
   assign w_last = (IF_STREAM != 0) ? bus.s_axis_tlast : 1'b1;

   always_comb begin
      w_next        = r_state;
      w_guard_ready = 1'b0;
      w_s_ready     = 1'b0;
      w_push        = 1'b0;
      w_inc_pass    = 1'b0;
      w_inc_drop    = 1'b0;
      w_end         = 1'b0;
      case (r_state)
         IDLE: begin
            w_guard_ready = 1'b1;
            if (bus.s_guard_cond_tvalid) begin
               w_next = token_state(bus.s_guard_cond_tdata);
            end
         end
         PASS: begin
            w_s_ready  = w_skid_ready;
            w_push     = bus.s_axis_tvalid && w_skid_ready;
            w_inc_pass = w_push && w_last;
            w_end      = w_inc_pass;
         end
         DROP: begin
            w_s_ready  = 1'b1;
            w_inc_drop = bus.s_axis_tvalid && w_last;
            w_end      = w_inc_drop;
         end
         default: w_next = IDLE;
      endcase
      // Closing beat also takes the next token so frames run back to back.
      if (w_end) begin
         w_guard_ready = 1'b1;
         w_next = bus.s_guard_cond_tvalid ? token_state(bus.s_guard_cond_tdata) : IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_pass_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_inc_pass) r_pass_cnt <= r_pass_cnt + CNT_ONE;
         if (w_inc_drop) r_drop_cnt <= r_drop_cnt + CNT_ONE;
      end
   end

   guard_skid #(
      .WIDTH (PW)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_data  ({bus.s_axis_tdata, bus.s_axis_tkeep, w_last}),
      .i_valid (w_push),
      .o_ready (w_skid_ready),
      .o_data  (w_skid_out),
      .o_valid (bus.m_axis_tvalid),
      .i_ready (bus.m_axis_tready)
   );

   assign {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast} = w_skid_out;
   assign bus.s_guard_cond_tready = w_guard_ready;
   assign bus.s_axis_tready       = w_s_ready;
   assign stat_pass_cnt           = r_pass_cnt;
   assign stat_drop_cnt           = r_drop_cnt;
   assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_guard_gate.sv
// Bench for guard_gate: one frame-stream build and one single-beat build share the
// same stimulus; sel picks which one the frame-level reference model observes.
module tb_guard_gate;
   import ep2_guard_pkg::*;

   localparam int DW = 32;
   localparam int KW = 4;
   localparam int CW = 32;
   localparam int BW = DW + KW + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   guard_gate_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) ifs ();
   guard_gate_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) ife ();

   logic [CW-1:0] pass_s, drop_s, pass_e, drop_e;
   guard_state_t  st_s, st_e;

   guard_gate #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .IF_STREAM(1), .CNT_WIDTH(CW)) dut_s (
      .clk(clk), .rst(rst), .bus(ifs.slave),
      .stat_pass_cnt(pass_s), .stat_drop_cnt(drop_s), .o_dbg_state(st_s));

   guard_gate #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .IF_STREAM(0), .CNT_WIDTH(CW)) dut_e (
      .clk(clk), .rst(rst), .bus(ife.slave),
      .stat_pass_cnt(pass_e), .stat_drop_cnt(drop_e), .o_dbg_state(st_e));

   // ---------------- shared drive signals ----------------
   logic          d_g_data, d_g_valid, d_s_valid, d_s_last, d_m_ready;
   logic [DW-1:0] d_s_data;
   logic [KW-1:0] d_s_keep;

   assign ifs.s_guard_cond_tdata  = d_g_data;
   assign ifs.s_guard_cond_tvalid = d_g_valid;
   assign ifs.s_axis_tdata        = d_s_data;
   assign ifs.s_axis_tkeep        = d_s_keep;
   assign ifs.s_axis_tlast        = d_s_last;
   assign ifs.s_axis_tvalid       = d_s_valid;
   assign ifs.m_axis_tready       = d_m_ready;
   assign ife.s_guard_cond_tdata  = d_g_data;
   assign ife.s_guard_cond_tvalid = d_g_valid;
   assign ife.s_axis_tdata        = d_s_data;
   assign ife.s_axis_tkeep        = d_s_keep;
   assign ife.s_axis_tlast        = d_s_last;
   assign ife.s_axis_tvalid       = d_s_valid;
   assign ife.m_axis_tready       = d_m_ready;

   // ---------------- observed instance ----------------
   logic          sel = 1'b0;
   logic          w_g_rdy, w_s_rdy, w_m_valid, w_m_last;
   logic [DW-1:0] w_m_data;
   logic [KW-1:0] w_m_keep;
   logic [CW-1:0] w_pass, w_drop;
   guard_state_t  w_st;

   assign w_g_rdy   = sel ? ife.s_guard_cond_tready : ifs.s_guard_cond_tready;
   assign w_s_rdy   = sel ? ife.s_axis_tready       : ifs.s_axis_tready;
   assign w_m_valid = sel ? ife.m_axis_tvalid       : ifs.m_axis_tvalid;
   assign w_m_last  = sel ? ife.m_axis_tlast        : ifs.m_axis_tlast;
   assign w_m_data  = sel ? ife.m_axis_tdata        : ifs.m_axis_tdata;
   assign w_m_keep  = sel ? ife.m_axis_tkeep        : ifs.m_axis_tkeep;
   assign w_pass    = sel ? pass_e : pass_s;
   assign w_drop    = sel ? drop_e : drop_s;
   assign w_st      = sel ? st_e   : st_s;

   // ---------------- model / scoreboard state ----------------
   logic [BW-1:0] exp_q[$];      // beats expected on m_axis, oldest first
   logic          mtok_q[$];     // tokens taken by the DUT whose frame is not closed
   logic [BW-1:0] drv_beat_q[$];
   logic          drv_tok_q[$];
   logic          mr_pat_q[$];
   int            m_pass, m_drop;
   int            n_vec = 0, n_err = 0;
   int            cyc = 0, beats_acc = 0, n_out = 0, first_cyc = -1, last_cyc = -1, max_occ = 0;
   int            tok_pct = 100, beat_pct = 100, mr_pct = 100;
   logic          tok_fire = 1'b0, beat_fire = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   // Called at the falling edge: compares, then records what the next rising edge accepts.
   task automatic monitor();
      logic in_frame, cur, eff_last, m_fire;
      cyc++;
      tok_fire  = 1'b0;
      beat_fire = 1'b0;
      if (!rst) begin
         exp_q.delete();
         mtok_q.delete();
         m_pass = 0;
         m_drop = 0;
         return;
      end
      in_frame = (mtok_q.size() != 0);
      cur      = in_frame ? mtok_q[0] : 1'b0;
      eff_last = sel ? 1'b1 : d_s_last;

      chk("pass_cnt", 64'(w_pass), 64'(m_pass));
      chk("drop_cnt", 64'(w_drop), 64'(m_drop));
      chk("m_tvalid", 64'(w_m_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0)
         chk("m_beat", 64'({w_m_data, w_m_keep, w_m_last}), 64'(exp_q[0]));
      if (!in_frame) begin
         chk("s_tready_idle", 64'(w_s_rdy), 64'(0));
         chk("g_tready_idle", 64'(w_g_rdy), 64'(1));
      end else begin
         if (cur) chk("s_tready_pass", 64'(w_s_rdy), 64'(exp_q.size() < 2));
         else     chk("s_tready_drop", 64'(w_s_rdy), 64'(1));
         chk("g_tready_frame", 64'(w_g_rdy), 64'(d_s_valid && w_s_rdy && eff_last));
      end
      if (exp_q.size() > max_occ) max_occ = exp_q.size();

      tok_fire  = d_g_valid && w_g_rdy;
      beat_fire = d_s_valid && w_s_rdy;
      m_fire    = w_m_valid && d_m_ready;
      if (m_fire && exp_q.size() != 0) begin
         void'(exp_q.pop_front());
         n_out++;
      end
      if (beat_fire) begin
         chk("beat_has_token", 64'(in_frame), 64'(1));
         if (in_frame) begin
            beats_acc++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (cur) exp_q.push_back({d_s_data, d_s_keep, eff_last});
            if (eff_last) begin
               void'(mtok_q.pop_front());
               if (cur) m_pass++;
               else     m_drop++;
            end
         end
      end
      if (tok_fire) begin
         mtok_q.push_back(d_g_data);
         chk("tok_depth", 64'(mtok_q.size() <= 1), 64'(1));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive();
      if (tok_fire)  void'(drv_tok_q.pop_front());
      if (beat_fire) void'(drv_beat_q.pop_front());
      if (drv_tok_q.size() == 0)     d_g_valid = 1'b0;
      else if (!d_g_valid || tok_fire) d_g_valid = ($urandom_range(99) < tok_pct);
      d_g_data = (drv_tok_q.size() != 0) ? drv_tok_q[0] : 1'b0;
      if (drv_beat_q.size() == 0)      d_s_valid = 1'b0;
      else if (!d_s_valid || beat_fire) d_s_valid = ($urandom_range(99) < beat_pct);
      if (drv_beat_q.size() != 0) {d_s_data, d_s_keep, d_s_last} = drv_beat_q[0];
      if (mr_pat_q.size() != 0) d_m_ready = mr_pat_q.pop_front();
      else                      d_m_ready = ($urandom_range(99) < mr_pct);
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic add_frame(input logic tok, input int nbeats);
      drv_tok_q.push_back(tok);
      for (int i = 0; i < nbeats; i++)
         drv_beat_q.push_back({DW'($urandom), KW'($urandom_range(15)), (i == nbeats - 1)});
   endtask

   task automatic do_reset();
      drv_tok_q.delete();
      drv_beat_q.delete();
      mr_pat_q.delete();
      d_g_valid = 1'b0;
      d_s_valid = 1'b0;
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      chk("rst_g_tready", 64'(w_g_rdy), 64'(1));
      chk("rst_s_tready", 64'(w_s_rdy), 64'(0));
      chk("rst_m_tvalid", 64'(w_m_valid), 64'(0));
      chk("rst_pass", 64'(w_pass), 64'(0));
      chk("rst_drop", 64'(w_drop), 64'(0));
      chk("rst_state", 64'(w_st), 64'(IDLE));
      beats_acc = 0;
      n_out     = 0;
      first_cyc = -1;
      last_cyc  = -1;
      max_occ   = 0;
   endtask

   task automatic run(input int max_cyc, input string tag);
      int n = 0;
      while ((drv_tok_q.size() != 0 || drv_beat_q.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
         step();
         n++;
      end
      chk(tag, 64'(n < max_cyc), 64'(1));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int np, nd, t, n;
      d_g_data = 1'b0; d_g_valid = 1'b0; d_s_valid = 1'b0; d_s_last = 1'b0;
      d_s_data = '0;   d_s_keep = '0;    d_m_ready = 1'b1;

      // Single pass frame, 3 beats, open downstream.
      do_reset();
      add_frame(1'b1, 3);
      run(50, "t1_done");
      chk("t1_pass", 64'(w_pass), 64'(1));
      chk("t1_drop", 64'(w_drop), 64'(0));
      chk("t1_out", 64'(n_out), 64'(3));

      // Drop frame under full backpressure: input keeps flowing.
      do_reset();
      mr_pct = 0;
      add_frame(1'b0, 4);
      run(50, "t2_done");
      chk("t2_drop", 64'(w_drop), 64'(1));
      chk("t2_pass", 64'(w_pass), 64'(0));
      chk("t2_span", 64'(last_cyc - first_cyc), 64'(3));
      mr_pct = 100;

      // Tokens 1,0,1 with 2-beat frames back to back: no bubbles.
      do_reset();
      add_frame(1'b1, 2);
      add_frame(1'b0, 2);
      add_frame(1'b1, 2);
      run(60, "t3_done");
      chk("t3_span", 64'(last_cyc - first_cyc), 64'(5));
      chk("t3_pass", 64'(w_pass), 64'(2));
      chk("t3_drop", 64'(w_drop), 64'(1));
      chk("t3_out", 64'(n_out), 64'(4));

      // Downstream stalls for two cycles: skid fills, nothing lost.
      do_reset();
      mr_pat_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      add_frame(1'b1, 5);
      run(60, "t4_done");
      chk("t4_max_occ", 64'(max_occ), 64'(2));
      chk("t4_out", 64'(n_out), 64'(5));
      chk("t4_pass", 64'(w_pass), 64'(1));

      // Reset in the middle of a pass frame, after one dropped frame was counted.
      do_reset();
      add_frame(1'b0, 1);
      add_frame(1'b1, 4);
      n = 0;
      while (beats_acc < 2 && n < 20) begin
         step();
         n++;
      end
      chk("t6_reach_beat2", 64'(beats_acc), 64'(2));
      drv_tok_q.delete();
      drv_beat_q.delete();
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("t6_m_tvalid", 64'(w_m_valid), 64'(0));
      chk("t6_pass", 64'(w_pass), 64'(0));
      chk("t6_drop", 64'(w_drop), 64'(0));
      chk("t6_state", 64'(w_st), 64'(IDLE));
      chk("t6_s_tready", 64'(w_s_rdy), 64'(0));
      beats_acc = 0;
      n_out = 0;
      for (int i = 0; i < 3; i++)
         drv_beat_q.push_back({DW'($urandom), KW'($urandom_range(15)), (i == 2)});
      for (int i = 0; i < 4; i++) step();
      chk("t6_stalled", 64'(beats_acc), 64'(0));
      drv_tok_q.push_back(1'b1);
      run(50, "t6_done");
      chk("t6_new_pass", 64'(w_pass), 64'(1));
      chk("t6_new_out", 64'(n_out), 64'(3));

      // Random soak on the frame-stream build.
      do_reset();
      tok_pct = 60; beat_pct = 70; mr_pct = 60;
      np = 0; nd = 0;
      for (int f = 0; f < 30; f++) begin
         t = $urandom_range(1);
         n = $urandom_range(1, 4);
         add_frame(t[0], n);
         if (t != 0) np++;
         else        nd++;
      end
      run(3000, "soak_s_done");
      chk("soak_s_pass", 64'(w_pass), 64'(np));
      chk("soak_s_drop", 64'(w_drop), 64'(nd));

      // Single-beat build: tokens 1,0,1,1 with tlast held low.
      sel = 1'b1;
      tok_pct = 100; beat_pct = 100; mr_pct = 100;
      do_reset();
      drv_tok_q = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++)
         drv_beat_q.push_back({DW'($urandom), KW'($urandom_range(15)), 1'b0});
      run(50, "t5_done");
      chk("t5_pass", 64'(w_pass), 64'(3));
      chk("t5_drop", 64'(w_drop), 64'(1));
      chk("t5_out", 64'(n_out), 64'(3));
      chk("t5_span", 64'(last_cyc - first_cyc), 64'(3));

      // Random soak on the single-beat build, tlast random.
      do_reset();
      tok_pct = 60; beat_pct = 70; mr_pct = 60;
      np = 0; nd = 0;
      for (int f = 0; f < 40; f++) begin
         t = $urandom_range(1);
         drv_tok_q.push_back(t[0]);
         drv_beat_q.push_back({DW'($urandom), KW'($urandom_range(15)), 1'($urandom_range(1))});
         if (t != 0) np++;
         else        nd++;
      end
      run(3000, "soak_e_done");
      chk("soak_e_pass", 64'(w_pass), 64'(np));
      chk("soak_e_drop", 64'(w_drop), 64'(nd));
      chk("soak_e_out", 64'(n_out), 64'(np));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
